median_window_col: RTL and testbench
====================================

MEDIAN_WINDOW_COL -- requirements
Module: median_window_col

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line (range 4..2048).
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame (range 3..2048).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port valid_i, input, 1 bit: pixel_i is valid this cycle and is accepted. There is no backpressure.
REQ-006 The block SHALL have port sof_i, input, 1 bit: start of frame, qualified by valid_i.
REQ-007 The block SHALL have port pixel_i, input, 8 bits: raster-order grey pixel.
REQ-008 The block SHALL have port valid_o, output, 1 bit: the column triple is valid.
REQ-009 The block SHALL have ports data0, data1 and data2, outputs, 8 bits each: the pixel from rows r-2, r-1 and r, all at column c.
REQ-010 The block SHALL have ports data0_id, data1_id and data2_id, outputs, 4 bits each: window-position tags of the triple.
REQ-011 The block SHALL have ports eol_o and eof_o, outputs, 1 bit each: the triple is the last of its line, or the last of its frame.

Function
REQ-012 The block SHALL keep col_cnt (0..IMG_WIDTH-1) and row_cnt (0..IMG_HEIGHT-1), giving the position (r,c) of the current accepted pixel.
REQ-013 On valid_i=1 with sof_i=1, the block SHALL treat the pixel as (0,0), regardless of the counter state; the next position is (0,1).
REQ-014 On valid_i=1 with sof_i=0, the block SHALL use the counters as the position, then advance them:
- col_cnt increments.
- At IMG_WIDTH-1, col_cnt wraps to 0 and row_cnt increments.
- At the end of line IMG_HEIGHT-1, row_cnt wraps to 0.
REQ-015 The block SHALL hold two line buffers, lb_a and lb_b, each IMG_WIDTH x 8 bits. On an accepted pixel at column c:
- read lb_a[c] (row r-2) and lb_b[c] (row r-1);
- then write lb_a[c] <= old lb_b[c] and lb_b[c] <= pixel_i.
REQ-016 A read and a write of the same address in the same cycle SHALL return the pre-write contents.
REQ-017 On valid_i=0, the block SHALL leave the counters and line buffers unchanged and drive valid_o=0 on the next cycle.
REQ-018 valid_o SHALL be registered, with latency exactly 1 cycle: valid_o=1 in cycle t+1 iff in cycle t valid_i=1 and the effective row r >= 2.
REQ-019 Rows 0 and 1 of every frame SHALL produce no valid_o, so each frame yields (IMG_HEIGHT-2)*IMG_WIDTH triples.
REQ-020 With valid_o=1, the outputs SHALL be: data0=pixel(r-2,c), data1=pixel(r-1,c), data2=pixel(r,c).
REQ-021 The ids SHALL be data0_id=3*(c mod 3)+0, data1_id=3*(c mod 3)+1 and data2_id=3*(c mod 3)+2, giving values 0..8.
- A mod-3 column phase counter SHALL be kept; it resets to 0 at col 0.
REQ-022 eol_o SHALL equal valid_o AND (c==IMG_WIDTH-1).
REQ-023 eof_o SHALL equal eol_o AND (r==IMG_HEIGHT-1).
REQ-024 When valid_o=0, the data, id, eol_o and eof_o outputs SHALL hold their previous values; downstream qualifies them by valid_o.
REQ-025 A sof_i arriving mid-frame SHALL abort the frame: the position restarts at (0,0), and rows 0 and 1 of the new frame are again suppressed, so stale line-buffer data is never emitted.

Reset
REQ-026 While reset=1 at a clock edge, the block SHALL clear valid_o, data0/1/2, the ids, eol_o, eof_o, col_cnt, row_cnt and the column phase to 0.
REQ-027 Line-buffer contents SHALL NOT be reset; REQ-018 guarantees that no unwritten entry is ever emitted.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first accepted pixel after reset SHALL be treated as (0,0) even when sof_i=0.
REQ-029 valid_i SHALL be ignored in any cycle in which reset=1.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 16*r+c)
REQ-030 Bench scenario, continuous frame: sof_i on the first pixel, 16 consecutive valid_i.
- valid_o is first high 1 cycle after pixel (2,0), giving data0/1/2 = 0x00/0x10/0x20 and ids 0/1/2.
- There are exactly 8 valid_o cycles.
- The last triple is 0x13/0x23/0x33 with ids 0/1/2, eol_o=1 and eof_o=1.
REQ-031 Bench scenario, gapped input: same frame with valid_i low on alternate cycles.
- The outputs are identical to the continuous case.
- valid_o is never high in the cycle after a valid_i=0 cycle.
REQ-032 Bench scenario, id phase: at row 2, columns 0..3.
- data2_id is 2, 5, 8, 2.
- eol_o is high only at column 3.
REQ-033 Bench scenario, mid-frame sof: sof_i at pixel (2,1) of frame 1.
- No valid_o occurs for the next 8 accepted pixels.
- The following triple is the new frame's (2,0).
REQ-034 Bench scenario, reset mid-frame: reset for 1 cycle after pixel (3,1), then continue with sof_i=0.
- All outputs read 0 the cycle after reset.
- The next 8 accepted pixels produce no valid_o.
REQ-035 Bench scenario, back-to-back frames: two frames with no gap.
- Frame 2 row-0/1 pixels produce no valid_o.
- Frame 2 triples never contain frame 1 values.

Source files
------------

// File: rtl/median_window_col_if.sv
// Pixel stream in / column-triple stream out for median_window_col.
// The producer/consumer side uses the master modport, the block the slave.
interface median_window_col_if;
   // pixel input stream
   logic       valid_i;
   logic       sof_i;
   logic [7:0] pixel_i;
   // column triple output stream
   logic       valid_o;
   logic [7:0] data0;
   logic [7:0] data1;
   logic [7:0] data2;
   logic [3:0] data0_id;
   logic [3:0] data1_id;
   logic [3:0] data2_id;
   logic       eol_o;
   logic       eof_o;

   modport master (
      output valid_i, sof_i, pixel_i,
      input  valid_o, data0, data1, data2,
             data0_id, data1_id, data2_id, eol_o, eof_o
   );

   modport slave (
      input  valid_i, sof_i, pixel_i,
      output valid_o, data0, data1, data2,
             data0_id, data1_id, data2_id, eol_o, eof_o
   );
endinterface

// File: rtl/median_window_col.sv
// Column-triple generator for a 3x3 median window.
// Two line buffers delay the raster stream by one and two lines so that for
// each accepted pixel (r,c) the block emits pixel(r-2,c), pixel(r-1,c) and
// pixel(r,c) one cycle later, together with window-position tags and
// end-of-line / end-of-frame markers. Rows 0 and 1 of a frame are never
// emitted, so line-buffer contents need no reset.
module median_window_col #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480
) (
   input  logic               clk,
   input  logic               reset,
   median_window_col_if.slave bus
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(2);

   // position counters and mod-3 column phase
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic [1:0]    ph_q,  ph_d;

   // effective position of the pixel on the bus this cycle
   logic [CW-1:0] col_eff;
   logic [RW-1:0] row_eff;
   logic [1:0]    ph_eff;

   logic          acc;
   logic          emit;
   logic          at_eol;
   logic          at_eof;

   // line buffers: lb_a holds row r-2, lb_b holds row r-1 (not reset)
   logic [7:0]    lb_a [IMG_WIDTH];
   logic [7:0]    lb_b [IMG_WIDTH];
   logic [7:0]    rd_a;
   logic [7:0]    rd_b;

   // registered outputs
   logic          valid_q;
   logic [7:0]    data0_q, data1_q, data2_q;
   logic [3:0]    id0_q, id1_q, id2_q;
   logic          eol_q, eof_q;
   logic [3:0]    id_base;

   // reset wins over valid_i; a reset cycle accepts nothing
   assign acc = bus.valid_i & ~reset;

   // sof forces the current pixel to (0,0) regardless of counter state
   always_comb begin
      col_eff = col_q;
      row_eff = row_q;
      ph_eff  = ph_q;
      if (bus.sof_i) begin
         col_eff = '0;
         row_eff = '0;
         ph_eff  = '0;
      end
   end

   assign at_eol = (col_eff == COL_LAST);
   assign at_eof = at_eol && (row_eff == ROW_LAST);
   assign emit   = acc && (row_eff >= ROW_FIRST_OUT);

   // advance position after an accepted pixel; hold otherwise
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      ph_d  = ph_q;
      if (acc) begin
         if (at_eol) begin
            col_d = '0;
            ph_d  = '0;
            row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
         end else begin
            col_d = col_eff + 1'b1;
            ph_d  = (ph_eff == 2'd2) ? 2'd0 : ph_eff + 2'd1;
            row_d = row_eff;
         end
      end
   end

   // position counter registers
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
         ph_q  <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
         ph_q  <= ph_d;
      end
   end

   // asynchronous read gives pre-write contents on same-address write
   assign rd_a = lb_a[col_eff];
   assign rd_b = lb_b[col_eff];

   // shift the column down one line: r-1 moves to r-2, new pixel becomes r-1
   always_ff @(posedge clk) begin
      if (acc) begin
         lb_a[col_eff] <= rd_b;
         lb_b[col_eff] <= bus.pixel_i;
      end
   end

   // tag base 3*(c mod 3)
   always_comb begin
      id_base = 4'd0;
      case (ph_eff)
         2'd1:    id_base = 4'd3;
         2'd2:    id_base = 4'd6;
         default: id_base = 4'd0;
      endcase
   end

   // output registers: valid every cycle, payload only on emitted triples
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         data0_q <= '0;
         data1_q <= '0;
         data2_q <= '0;
         id0_q   <= '0;
         id1_q   <= '0;
         id2_q   <= '0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         valid_q <= emit;
         if (emit) begin
            data0_q <= rd_a;
            data1_q <= rd_b;
            data2_q <= bus.pixel_i;
            id0_q   <= id_base;
            id1_q   <= id_base + 4'd1;
            id2_q   <= id_base + 4'd2;
            eol_q   <= at_eol;
            eof_q   <= at_eof;
         end
      end
   end

   assign bus.valid_o  = valid_q;
   assign bus.data0    = data0_q;
   assign bus.data1    = data1_q;
   assign bus.data2    = data2_q;
   assign bus.data0_id = id0_q;
   assign bus.data1_id = id1_q;
   assign bus.data2_id = id2_q;
   assign bus.eol_o    = eol_q;
   assign bus.eof_o    = eof_q;

endmodule

// File: tb/tb_median_window_col.sv
// Directed bench for median_window_col on a 4x4 image, pixel = 16*r+c.
// A frame table holds inputs and hand-derived expected triples; frames are
// replayed with a value offset (OR-ed into the high bits) so triples from
// different frames can be told apart.
module tb_median_window_col;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   int   vcount;

   median_window_col_if bus ();

   median_window_col #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sof;
      logic [7:0] pix;
      logic       ev;
      logic [7:0] d0, d1, d2;
      logic [3:0] i0, i1, i2;
      logic       eol, eof;
   } vec_t;

   vec_t tbl [16];
   int   ID0 [4] = '{0, 3, 6, 0};

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic v, input logic s, input logic [7:0] p);
      @(negedge clk);
      reset       = rst;
      bus.valid_i = v;
      bus.sof_i   = s;
      bus.pixel_i = p;
      @(posedge clk);
      #1;
   endtask

   // apply the first n table entries; gap inserts an idle cycle after each
   task automatic run_frame(input logic [7:0] off, input int n, input bit gap, input bit nosof);
      logic sof;
      for (int k = 0; k < n; k++) begin
         sof = tbl[k].sof & ~nosof;
         step(1'b0, 1'b1, sof, tbl[k].pix | off);
         chk($sformatf("valid_o[%0d]", k), bus.valid_o, tbl[k].ev);
         if (tbl[k].ev) begin
            vcount++;
            chk($sformatf("data0[%0d]", k), bus.data0, tbl[k].d0 | off);
            chk($sformatf("data1[%0d]", k), bus.data1, tbl[k].d1 | off);
            chk($sformatf("data2[%0d]", k), bus.data2, tbl[k].d2 | off);
            chk($sformatf("data0_id[%0d]", k), bus.data0_id, tbl[k].i0);
            chk($sformatf("data1_id[%0d]", k), bus.data1_id, tbl[k].i1);
            chk($sformatf("data2_id[%0d]", k), bus.data2_id, tbl[k].i2);
            chk($sformatf("eol_o[%0d]", k), bus.eol_o, tbl[k].eol);
            chk($sformatf("eof_o[%0d]", k), bus.eof_o, tbl[k].eof);
         end
         if (gap) begin
            step(1'b0, 1'b0, 1'b0, 8'hFF);
            chk($sformatf("gap valid_o[%0d]", k), bus.valid_o, 0);
            if (tbl[k].ev)
               chk($sformatf("gap hold data2[%0d]", k), bus.data2, tbl[k].d2 | off);
         end
      end
   endtask

   initial begin
      tests = 0; fails = 0; vcount = 0;
      reset = 1'b1; bus.valid_i = 1'b0; bus.sof_i = 1'b0; bus.pixel_i = '0;

      // expected triple for pixel (r,c): rows r-2, r-1, r at column c
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            tbl[4*r+c].sof = (r == 0 && c == 0);
            tbl[4*r+c].pix = 8'(16*r + c);
            tbl[4*r+c].ev  = (r >= 2);
            tbl[4*r+c].d0  = 8'(16*(r-2) + c);
            tbl[4*r+c].d1  = 8'(16*(r-1) + c);
            tbl[4*r+c].d2  = 8'(16*r + c);
            tbl[4*r+c].i0  = 4'(ID0[c]);
            tbl[4*r+c].i1  = 4'(ID0[c] + 1);
            tbl[4*r+c].i2  = 4'(ID0[c] + 2);
            tbl[4*r+c].eol = (c == 3);
            tbl[4*r+c].eof = (c == 3 && r == 3);
         end

      // reset state, with valid_i high to show it is ignored
      step(1'b1, 1'b1, 1'b0, 8'h55);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("rst valid_o", bus.valid_o, 0);
      chk("rst data0",   bus.data0, 0);
      chk("rst data2",   bus.data2, 0);
      chk("rst data2_id", bus.data2_id, 0);
      chk("rst eof_o",   bus.eof_o, 0);

      // continuous frame, then a back-to-back frame with distinct values
      vcount = 0;
      run_frame(8'h00, 16, 1'b0, 1'b0);
      chk("cont valid count", vcount, 8);
      vcount = 0;
      run_frame(8'h80, 16, 1'b0, 1'b0);
      chk("b2b valid count", vcount, 8);

      // gapped frame
      vcount = 0;
      run_frame(8'h00, 16, 1'b1, 1'b0);
      chk("gap valid count", vcount, 8);

      // mid-frame sof at (2,1): new frame restarts, rows 0/1 suppressed
      run_frame(8'h00, 9, 1'b0, 1'b0);
      vcount = 0;
      run_frame(8'h40, 8, 1'b0, 1'b0);
      chk("midsof suppressed", vcount, 0);
      step(1'b0, 1'b1, 1'b0, 8'h60);
      chk("midsof valid_o", bus.valid_o, 1);
      chk("midsof data0",   bus.data0, 8'h40);
      chk("midsof data1",   bus.data1, 8'h50);
      chk("midsof data2",   bus.data2, 8'h60);

      // reset after (3,1), then resume without sof
      run_frame(8'h00, 14, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      chk("mrst valid_o", bus.valid_o, 0);
      chk("mrst data0",   bus.data0, 0);
      chk("mrst data1",   bus.data1, 0);
      chk("mrst data2",   bus.data2, 0);
      chk("mrst data0_id", bus.data0_id, 0);
      chk("mrst data1_id", bus.data1_id, 0);
      chk("mrst data2_id", bus.data2_id, 0);
      chk("mrst eol_o",   bus.eol_o, 0);
      chk("mrst eof_o",   bus.eof_o, 0);
      vcount = 0;
      run_frame(8'hC0, 16, 1'b0, 1'b1);
      chk("mrst valid count", vcount, 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
